// File: rtl/idma_obi_ctrl_initiator_pkg.sv
// Shared types and constants for the iDMA control-window initiator and its decoder peer.
// Latency: n/a (types, constants and a pure address helper only).
// Backpressure: n/a.
package idma_obi_ctrl_initiator_pkg;

  // OBI channel layout used on the tile data crossbar
  localparam int unsigned OBI_IDW = 1;

  typedef struct packed {
    logic [31:0]        addr;
    logic               we;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic [OBI_IDW-1:0] aid;
    logic               a_optional;
  } core_obi_data_a_chan_t;

  typedef struct packed {
    core_obi_data_a_chan_t a;
    logic                  req;
  } core_obi_data_req_t;

  typedef struct packed {
    logic [31:0]        rdata;
    logic [OBI_IDW-1:0] rid;
    logic               err;
    logic               r_optional;
  } core_obi_data_r_chan_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    core_obi_data_r_chan_t r;
  } core_obi_data_rsp_t;

  // Base of the iDMA control window; bit 8 must stay clear so it can carry the direction
  localparam logic [31:0] IDMA_CTRL_ADDR_START = 32'h0002_0000;

  // Register offsets inside one direction's half of the window (shared with the decoder)
  localparam logic [31:0] IDMA_REG_DST_OFFSET       = 32'h0000_00D0;
  localparam logic [31:0] IDMA_REG_SRC_OFFSET       = 32'h0000_00D8;
  localparam logic [31:0] IDMA_REG_LENGTH_OFFSET    = 32'h0000_00E0;
  localparam logic [31:0] IDMA_REG_NEXT_ID_0_OFFSET = 32'h0000_0044;
  localparam logic [31:0] IDMA_REG_DONE_ID_0_OFFSET = 32'h0000_0084;

  // Address bit selecting AXI2OBI (0) or OBI2AXI (1) register bank
  localparam int unsigned IDMA_DIR_BIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_DST    = 3'd1,
    ST_WR_SRC    = 3'd2,
    ST_WR_LEN    = 3'd3,
    ST_RD_NEXT   = 3'd4,
    ST_POLL_WAIT = 3'd5,
    ST_RD_DONE   = 3'd6,
    ST_RESP      = 3'd7
  } idma_init_state_e;

  // Full bus address of a control register in the bank chosen by dir
  function automatic logic [31:0] idma_ctrl_addr(input logic [31:0] off, input logic dir);
    logic [31:0] a;
    a = IDMA_CTRL_ADDR_START + off;
    a[IDMA_DIR_BIT] = dir;
    return a;
  endfunction

endpackage

// File: rtl/idma_obi_ctrl_initiator_if.sv
// OBI request/response bundle between an initiator and the crossbar or a slave model.
// Latency: none, plain wires.
// Backpressure: carried by the gnt/rvalid fields of the response.
interface idma_obi_ctrl_initiator_if #(
  parameter type obi_req_t = idma_obi_ctrl_initiator_pkg::core_obi_data_req_t,
  parameter type obi_rsp_t = idma_obi_ctrl_initiator_pkg::core_obi_data_rsp_t
) ();

  obi_req_t req;
  obi_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/idma_obi_ctrl_initiator_single_access.sv
// Single outstanding OBI access: raises req while start_i is held, then waits for rvalid.
// Latency: done_o in the gnt cycle when rvalid comes with gnt, else in the rvalid cycle.
// Backpressure: req/addr/wdata held stable until gnt; no new request while a response is pending.
module idma_obi_single_access (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  idma_obi_ctrl_initiator_if.master bus
);

  logic rsp_pend_q, rsp_pend_d;
  logic issue;

  // REQ phase lasts while the caller holds start and no response is outstanding
  assign issue   = start_i && !rsp_pend_q;
  assign done_o  = (issue && bus.rsp.gnt && bus.rsp.rvalid) || (rsp_pend_q && bus.rsp.rvalid);
  assign err_o   = done_o && bus.rsp.r.err;
  assign rdata_o = bus.rsp.r.rdata;

  // Drive the request channel; every field is zero outside the REQ phase
  always_comb begin
    bus.req = '0;
    if (issue) begin
      bus.req.req     = 1'b1;
      bus.req.a.addr  = addr_i;
      bus.req.a.we    = we_i;
      bus.req.a.be    = 4'hF;
      bus.req.a.wdata = we_i ? wdata_i : 32'h0;
    end
  end

  // Track the RSP phase: granted but response not yet seen
  always_comb begin
    rsp_pend_d = rsp_pend_q;
    if (issue && bus.rsp.gnt && !bus.rsp.rvalid) begin
      rsp_pend_d = 1'b1;
    end else if (rsp_pend_q && bus.rsp.rvalid) begin
      rsp_pend_d = 1'b0;
    end
  end

  // Pending flag register; reset drops any in-flight response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_pend_q <= 1'b0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
    end
  end

endmodule

// File: rtl/idma_obi_ctrl_initiator.sv
// Programs DST/SRC/LENGTH of the iDMA control window, launches via NEXT_ID, polls DONE_ID.
// Latency: POLL_GAP+6 cycles accept-to-done with a zero-wait slave and a first-poll match.
// Backpressure: one descriptor at a time (ready only in IDLE); done held until done_ready_i.
module idma_obi_ctrl_initiator
  import idma_obi_ctrl_initiator_pkg::*;
#(
  parameter type         obi_req_t = core_obi_data_req_t,
  parameter type         obi_rsp_t = core_obi_data_rsp_t,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        desc_valid_i,
  output logic        desc_ready_o,
  input  logic        desc_dir_i,
  input  logic [31:0] desc_src_i,
  input  logic [31:0] desc_dst_i,
  input  logic [31:0] desc_len_i,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i,
  output logic        done_valid_o,
  input  logic        done_ready_i,
  output logic [31:0] done_id_o,
  output logic        done_err_o,
  output logic        busy_o
);

  localparam logic [31:0] GapLast  = (POLL_GAP == 0) ? 32'd0 : POLL_GAP - 32'd1;
  localparam logic [31:0] MaxPolls = MAX_POLLS;

  idma_obi_ctrl_initiator_if #(.obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t)) bus ();

  assign obi_req_o = bus.req;
  assign bus.rsp   = obi_rsp_i;

  idma_init_state_e state_q;
  logic             dir_q;
  logic [31:0]      src_q, dst_q, len_q;
  logic [31:0]      launch_id_q, gap_cnt_q, poll_cnt_q;
  logic             done_valid_q, done_err_q;
  logic [31:0]      done_id_q;

  logic        acc_start, acc_we, acc_done, acc_err;
  logic [31:0] acc_addr, acc_wdata, acc_rdata;

  // Decode which register access the current state performs
  always_comb begin
    acc_start = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = 32'h0;
    acc_wdata = 32'h0;
    case (state_q)
      ST_WR_DST: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = idma_ctrl_addr(IDMA_REG_DST_OFFSET, dir_q);
        acc_wdata = dst_q;
      end
      ST_WR_SRC: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = idma_ctrl_addr(IDMA_REG_SRC_OFFSET, dir_q);
        acc_wdata = src_q;
      end
      ST_WR_LEN: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = idma_ctrl_addr(IDMA_REG_LENGTH_OFFSET, dir_q);
        acc_wdata = len_q;
      end
      ST_RD_NEXT: begin
        acc_start = 1'b1;
        acc_addr  = idma_ctrl_addr(IDMA_REG_NEXT_ID_0_OFFSET, dir_q);
      end
      ST_RD_DONE: begin
        acc_start = 1'b1;
        acc_addr  = idma_ctrl_addr(IDMA_REG_DONE_ID_0_OFFSET, dir_q);
      end
      default: ;
    endcase
  end

  idma_obi_single_access i_access (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (acc_start),
    .we_i    (acc_we),
    .addr_i  (acc_addr),
    .wdata_i (acc_wdata),
    .done_o  (acc_done),
    .rdata_o (acc_rdata),
    .err_o   (acc_err),
    .bus     (bus)
  );

  // Sequencer: latch descriptor, walk the register accesses, poll, report completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      dir_q        <= 1'b0;
      src_q        <= 32'h0;
      dst_q        <= 32'h0;
      len_q        <= 32'h0;
      launch_id_q  <= 32'h0;
      gap_cnt_q    <= 32'h0;
      poll_cnt_q   <= 32'h0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_id_q    <= 32'h0;
    end else if (acc_done && acc_err) begin
      // Bus error aborts the sequence; report whatever ID has been launched so far
      state_q      <= ST_RESP;
      done_valid_q <= 1'b1;
      done_err_q   <= 1'b1;
      done_id_q    <= launch_id_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (desc_valid_i) begin
            dir_q       <= desc_dir_i;
            src_q       <= desc_src_i;
            dst_q       <= desc_dst_i;
            len_q       <= desc_len_i;
            launch_id_q <= 32'h0;
            poll_cnt_q  <= 32'h0;
            if (desc_len_i == 32'h0) begin
              state_q      <= ST_RESP;
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b0;
              done_id_q    <= 32'h0;
            end else begin
              state_q <= ST_WR_DST;
            end
          end
        end
        ST_WR_DST: if (acc_done) state_q <= ST_WR_SRC;
        ST_WR_SRC: if (acc_done) state_q <= ST_WR_LEN;
        ST_WR_LEN: if (acc_done) state_q <= ST_RD_NEXT;
        ST_RD_NEXT: begin
          if (acc_done) begin
            launch_id_q <= acc_rdata;
            gap_cnt_q   <= 32'h0;
            state_q     <= (POLL_GAP == 0) ? ST_RD_DONE : ST_POLL_WAIT;
          end
        end
        ST_POLL_WAIT: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= ST_RD_DONE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 32'd1;
          end
        end
        ST_RD_DONE: begin
          if (acc_done) begin
            if (acc_rdata == launch_id_q) begin
              state_q      <= ST_RESP;
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b0;
              done_id_q    <= launch_id_q;
            end else if ((MaxPolls != 32'h0) && (poll_cnt_q + 32'd1 == MaxPolls)) begin
              state_q      <= ST_RESP;
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b1;
              done_id_q    <= launch_id_q;
            end else begin
              poll_cnt_q <= poll_cnt_q + 32'd1;
              gap_cnt_q  <= 32'h0;
              state_q    <= (POLL_GAP == 0) ? ST_RD_DONE : ST_POLL_WAIT;
            end
          end
        end
        ST_RESP: begin
          if (done_ready_i) begin
            state_q      <= ST_IDLE;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            done_id_q    <= 32'h0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign desc_ready_o = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_valid_o = done_valid_q;
  assign done_err_o   = done_err_q;
  assign done_id_o    = done_id_q;

endmodule

// File: tb/tb_idma_obi_ctrl_initiator.sv
// Directed bench: two initiators (POLL_GAP=4/unlimited polls and POLL_GAP=0/3 polls) share one OBI slave model.
// Latency: expected cycle counts are hand-derived per scenario.
// Backpressure: slave model can stall gnt on the SRC write or return rvalid one cycle after gnt.
module tb_idma_obi_ctrl_initiator;
  import idma_obi_ctrl_initiator_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel;
  logic        desc_valid, desc_dir, done_ready;
  logic [31:0] desc_src, desc_dst, desc_len;
  logic        rdy_a, rdy_b, dv_a, dv_b, derr_a, derr_b, busy_a, busy_b;
  logic [31:0] did_a, did_b;

  idma_obi_ctrl_initiator_if bus_a ();
  idma_obi_ctrl_initiator_if bus_b ();

  idma_obi_ctrl_initiator #(.POLL_GAP(4), .MAX_POLLS(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .desc_valid_i(desc_valid && !sel), .desc_ready_o(rdy_a), .desc_dir_i(desc_dir),
    .desc_src_i(desc_src), .desc_dst_i(desc_dst), .desc_len_i(desc_len),
    .obi_req_o(bus_a.req), .obi_rsp_i(bus_a.rsp),
    .done_valid_o(dv_a), .done_ready_i(done_ready && !sel), .done_id_o(did_a),
    .done_err_o(derr_a), .busy_o(busy_a)
  );

  idma_obi_ctrl_initiator #(.POLL_GAP(0), .MAX_POLLS(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .desc_valid_i(desc_valid && sel), .desc_ready_o(rdy_b), .desc_dir_i(desc_dir),
    .desc_src_i(desc_src), .desc_dst_i(desc_dst), .desc_len_i(desc_len),
    .obi_req_o(bus_b.req), .obi_rsp_i(bus_b.rsp),
    .done_valid_o(dv_b), .done_ready_i(done_ready && sel), .done_id_o(did_b),
    .done_err_o(derr_b), .busy_o(busy_b)
  );

  // Selected DUT view
  logic        dv, derr, rdy, busy;
  logic [31:0] did;
  assign dv   = sel ? dv_b   : dv_a;
  assign derr = sel ? derr_b : derr_a;
  assign rdy  = sel ? rdy_b  : rdy_a;
  assign busy = sel ? busy_b : busy_a;
  assign did  = sel ? did_b  : did_a;

  // ---------------- OBI slave model ----------------
  logic        cfg_gnt_src, cfg_late, cfg_err_en, m_clr;
  logic [7:0]  cfg_err_off;
  logic [31:0] cfg_next_id;
  int          cfg_match;

  core_obi_data_req_t    m_req;
  core_obi_data_rsp_t    m_rsp;
  core_obi_data_a_chan_t prev_a;
  logic        m_gnt, pend, pend_err;
  logic [31:0] pend_rdata, m_rdata;
  logic [7:0]  m_off;
  int          gnt_cnt, n_acc, n_done, n_wait, stab_viol, bad_fld;
  logic [31:0] log_addr [16];
  logic [31:0] log_wdata[16];
  logic        log_we   [16];

  assign m_req = sel ? bus_b.req : bus_a.req;
  assign bus_a.rsp = m_rsp;
  assign bus_b.rsp = m_rsp;
  assign m_off = m_req.a.addr[7:0];

  always_comb begin
    m_rdata = 32'h0;
    if (m_off == 8'h44) m_rdata = cfg_next_id;
    else if (m_off == 8'h84) m_rdata = (n_done < cfg_match) ? cfg_next_id - 32'd1 : cfg_next_id;
  end

  always_comb begin
    m_rsp = '0;
    m_gnt = m_req.req && (gnt_cnt >= ((cfg_gnt_src && m_off == 8'hD8) ? 3 : 0));
    m_rsp.gnt = m_gnt;
    if (cfg_late) begin
      m_rsp.rvalid  = pend;
      m_rsp.r.rdata = pend_rdata;
      m_rsp.r.err   = pend && pend_err;
    end else begin
      m_rsp.rvalid  = m_gnt;
      m_rsp.r.rdata = m_rdata;
      m_rsp.r.err   = m_gnt && cfg_err_en && (m_off == cfg_err_off);
    end
  end

  always @(posedge clk) begin
    if (!rst_n || m_clr) begin
      gnt_cnt <= 0; pend <= 1'b0; n_acc <= 0; n_done <= 0;
      n_wait <= 0; stab_viol <= 0; bad_fld <= 0;
    end else begin
      if (pend) pend <= 1'b0;
      if (m_req.req) begin
        if (m_req.a.aid != '0 || (m_req.a.we && m_req.a.be != 4'hF) || pend) bad_fld <= bad_fld + 1;
        if (gnt_cnt != 0 && m_req.a != prev_a) stab_viol <= stab_viol + 1;
        prev_a <= m_req.a;
        if (m_gnt) begin
          gnt_cnt <= 0;
          log_addr[n_acc[3:0]]  <= m_req.a.addr;
          log_wdata[n_acc[3:0]] <= m_req.a.wdata;
          log_we[n_acc[3:0]]    <= m_req.a.we;
          n_acc <= n_acc + 1;
          if (m_off == 8'h84) n_done <= n_done + 1;
          if (cfg_late) begin
            pend       <= 1'b1;
            pend_rdata <= m_rdata;
            pend_err   <= cfg_err_en && (m_off == cfg_err_off);
          end
        end else begin
          gnt_cnt <= gnt_cnt + 1;
          n_wait  <= n_wait + 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_pass = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic setup(input logic s, input logic gsrc, input logic late, input logic erren,
                       input logic [7:0] eoff, input logic [31:0] nid, input int match);
    sel = s; cfg_gnt_src = gsrc; cfg_late = late; cfg_err_en = erren;
    cfg_err_off = eoff; cfg_next_id = nid; cfg_match = match;
    m_clr = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
  endtask

  task automatic present(input logic dir, input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] len);
    @(negedge clk);
    desc_valid = 1'b1; desc_dir = dir; desc_src = src; desc_dst = dst; desc_len = len;
    @(negedge clk);
    desc_valid = 1'b0; desc_dir = ~dir;
    desc_src = 32'hDEAD_BEEF; desc_dst = 32'hDEAD_BEEF; desc_len = 32'hDEAD_BEEF;
  endtask

  task automatic run(input logic dir, input logic [31:0] src, input logic [31:0] dst,
                     input logic [31:0] len);
    present(dir, src, dst, len);
    cyc = 1;
    while (!dv && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (!dv) chk("done_timeout", 32'(dv), 32'd1);
  endtask

  task automatic ack();
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hold_bad;
    rst_n = 1'b0; sel = 1'b0; m_clr = 1'b0; desc_valid = 1'b0; desc_dir = 1'b0;
    desc_src = 32'h0; desc_dst = 32'h0; desc_len = 32'h0; done_ready = 1'b0;
    cfg_gnt_src = 1'b0; cfg_late = 1'b0; cfg_err_en = 1'b0; cfg_err_off = 8'h0;
    cfg_next_id = 32'h0; cfg_match = 0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_obi_req_zero", 32'(bus_a.req !== '0), 32'd0);
    chk("rst_done_valid",   32'(dv_a), 32'd0);
    chk("rst_busy",         32'(busy_a), 32'd0);
    chk("rst_done_id",      did_a, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_desc_ready",  32'(rdy_a), 32'd1);

    // Zero-wait, dir 0, one mismatching poll, then hold done_ready low
    setup(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd5, 1);
    run(1'b0, 32'h1000, 32'h2000, 32'd64);
    chk("t1_done_id",   did, 32'd5);
    chk("t1_done_err",  32'(derr), 32'd0);
    chk("t1_n_access",  n_acc, 32'd6);
    chk("t1_done_reads", n_done, 32'd2);
    chk("t1_dst_addr",  log_addr[0], 32'h0002_00D0);
    chk("t1_dst_data",  log_wdata[0], 32'h2000);
    chk("t1_src_addr",  log_addr[1], 32'h0002_00D8);
    chk("t1_src_data",  log_wdata[1], 32'h1000);
    chk("t1_len_addr",  log_addr[2], 32'h0002_00E0);
    chk("t1_len_data",  log_wdata[2], 32'h40);
    chk("t1_next_addr", log_addr[3], 32'h0002_0044);
    chk("t1_next_we",   32'(log_we[3]), 32'd0);
    chk("t1_poll_addr", log_addr[5], 32'h0002_0084);
    chk("t1_fields",    bad_fld, 32'd0);
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dv !== 1'b1 || did !== 32'd5 || derr !== 1'b0 || rdy !== 1'b0) hold_bad++;
    end
    chk("hold_stable", hold_bad, 32'd0);
    ack();
    chk("after_ack_ready", 32'(rdy), 32'd1);
    chk("after_ack_valid", 32'(dv), 32'd0);

    // Best-case latency, POLL_GAP=4: done visible in cycle 10 after accept
    setup(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd5, 0);
    run(1'b0, 32'h3000, 32'h4000, 32'd16);
    chk("lat_zero_wait", cyc, 32'd10);
    chk("lat_done_reads", n_done, 32'd1);
    ack();

    // dir 1: bit 8 set on every address
    setup(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd7, 1);
    run(1'b1, 32'h1000, 32'h2000, 32'd8);
    chk("dir1_dst_addr",  log_addr[0], 32'h0002_01D0);
    chk("dir1_len_addr",  log_addr[2], 32'h0002_01E0);
    chk("dir1_next_addr", log_addr[3], 32'h0002_0144);
    chk("dir1_poll_addr", log_addr[4], 32'h0002_0184);
    chk("dir1_done_id",   did, 32'd7);
    ack();

    // gnt stalled 3 cycles on the SRC write
    setup(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'd5, 0);
    run(1'b0, 32'hA0A0_0000, 32'h2000, 32'd4);
    chk("stall_stable",   stab_viol, 32'd0);
    chk("stall_wait_cyc", n_wait, 32'd3);
    chk("stall_n_access", n_acc, 32'd5);
    chk("stall_src_data", log_wdata[1], 32'hA0A0_0000);
    chk("stall_done_id",  did, 32'd5);
    ack();

    // rvalid one cycle after gnt: 2 cycles per access
    setup(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'd5, 0);
    run(1'b0, 32'h1000, 32'h2000, 32'd4);
    chk("late_latency", cyc, 32'd15);
    chk("late_n_access", n_acc, 32'd5);
    chk("late_fields",  bad_fld, 32'd0);
    chk("late_done_id", did, 32'd5);
    ack();

    // Bus error on the LENGTH write
    setup(1'b0, 1'b0, 1'b0, 1'b1, 8'hE0, 32'd5, 0);
    run(1'b0, 32'h1000, 32'h2000, 32'd4);
    chk("err_n_access", n_acc, 32'd3);
    chk("err_done_err", 32'(derr), 32'd1);
    chk("err_done_id",  did, 32'd0);
    ack();

    // Zero-length descriptor: no bus traffic
    setup(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd5, 0);
    run(1'b0, 32'h1, 32'h2, 32'd0);
    chk("len0_n_access", n_acc, 32'd0);
    chk("len0_latency",  32'(cyc <= 2), 32'd1);
    chk("len0_done_id",  did, 32'd0);
    chk("len0_done_err", 32'(derr), 32'd0);
    ack();

    // MAX_POLLS=3, DONE_ID never matches
    setup(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd9, 100);
    run(1'b0, 32'h1000, 32'h2000, 32'd32);
    chk("tmo_done_reads", n_done, 32'd3);
    chk("tmo_done_err",   32'(derr), 32'd1);
    chk("tmo_done_id",    did, 32'd9);
    ack();

    // POLL_GAP=0 best case: done in cycle 6
    setup(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd9, 0);
    run(1'b0, 32'h1000, 32'h2000, 32'd32);
    chk("gap0_latency",  cyc, 32'd6);
    chk("gap0_done_id",  did, 32'd9);
    chk("gap0_done_err", 32'(derr), 32'd0);
    ack();

    // Reset while polling
    setup(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd5, 100);
    present(1'b0, 32'h1000, 32'h2000, 32'd64);
    repeat (5) @(negedge clk);
    chk("prerst_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",    32'(busy_a), 32'd0);
    chk("midrst_valid",   32'(dv_a), 32'd0);
    chk("midrst_obi_req", 32'(bus_a.req !== '0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(rdy_a), 32'd1);
    setup(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd5, 0);
    run(1'b0, 32'h1000, 32'h2000, 32'd64);
    chk("postrst_done_id", did, 32'd5);
    chk("postrst_n_access", n_acc, 32'd5);
    ack();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
